// File: rtl/pf_lpddr3_dm_lane_tx_seq_if.sv
// Controller/IOD-facing signal bundle of one LPDDR3 DM lane sequencer.
// The sequencer takes the slave modport; the controller/IOD model takes master.
interface pf_lpddr3_dm_lane_tx_seq_if;
  logic       WR_VALID;
  logic       WR_READY;
  logic [7:0] WR_MASK;
  logic [3:0] WL_CYC;
  logic       ODT_REQ;
  logic       DLY_REQ;
  logic       DLY_DIR;
  logic [7:0] DLY_STEPS;
  logic       DLY_LOAD_REQ;
  logic       DLY_BUSY;
  logic       DLY_DONE;
  logic       DLY_ERR;
  logic [7:0] TX_DATA_0;
  logic [3:0] OE_DATA_0;
  logic       ODT_EN_0;
  logic       DELAY_LINE_MOVE_0;
  logic       DELAY_LINE_DIRECTION_0;
  logic       DELAY_LINE_LOAD_0;
  logic       DELAY_LINE_OUT_OF_RANGE_0;

  modport slave (
    input  WR_VALID, WR_MASK, WL_CYC, ODT_REQ, DLY_REQ, DLY_DIR, DLY_STEPS,
           DLY_LOAD_REQ, DELAY_LINE_OUT_OF_RANGE_0,
    output WR_READY, DLY_BUSY, DLY_DONE, DLY_ERR, TX_DATA_0, OE_DATA_0, ODT_EN_0,
           DELAY_LINE_MOVE_0, DELAY_LINE_DIRECTION_0, DELAY_LINE_LOAD_0
  );

  modport master (
    output WR_VALID, WR_MASK, WL_CYC, ODT_REQ, DLY_REQ, DLY_DIR, DLY_STEPS,
           DLY_LOAD_REQ, DELAY_LINE_OUT_OF_RANGE_0,
    input  WR_READY, DLY_BUSY, DLY_DONE, DLY_ERR, TX_DATA_0, OE_DATA_0, ODT_EN_0,
           DELAY_LINE_MOVE_0, DELAY_LINE_DIRECTION_0, DELAY_LINE_LOAD_0
  );
endinterface

// File: rtl/pf_lpddr3_dm_lane_tx_seq.sv
// LPDDR3 DM lane sequencer: write-latency delayed mask/OE/ODT words for the IOD,
// plus a delay-line stepper that only runs once the write pipeline has drained.
module pf_lpddr3_dm_lane_tx_seq #(
  parameter int MAX_WL   = 12,
  parameter int STEP_GAP = 4
) (
  input  logic                          FAB_CLK,
  input  logic                          ARST_N,
  pf_lpddr3_dm_lane_tx_seq_if.slave     bus
);
  localparam int WLW = $clog2(MAX_WL + 1);
  localparam int GW  = $clog2(STEP_GAP);

  typedef enum logic [2:0] {
    S_IDLE, S_DRAIN, S_LOAD, S_SETUP, S_MOVE, S_GAP, S_DONE
  } state_t;

  state_t          state_q;
  logic [7:0]      steps_q;
  logic [GW-1:0]   gap_q;
  logic            dir_lat_q;
  logic            is_load_q;
  logic            dir_q;
  logic            move_q;
  logic            load_q;
  logic            done_q;
  logic            err_q;
  logic            run_q;

  logic [WLW-1:0]  wl_q;
  logic [WLW-1:0]  wl_clamp;
  logic [WLW-1:0]  wl_eff;
  logic [MAX_WL:1] vld_q;
  logic [MAX_WL:1] vld_d;
  logic [7:0]      msk_q [1:MAX_WL];
  logic [7:0]      msk_d [1:MAX_WL];

  logic [7:0]      tx_q;
  logic [3:0]      oe_q;
  logic [3:0]      oe_d;
  logic            odt_q;
  logic            burst_q;

  logic            wr_ready;
  logic            accept;
  logic            pipe_empty;

  assign pipe_empty = ~|vld_q;
  assign wr_ready   = run_q & (state_q == S_IDLE) & ~bus.DLY_REQ & ~bus.DLY_LOAD_REQ;
  assign accept     = bus.WR_VALID & wr_ready;

  always_comb begin
    if (bus.WL_CYC < 4'd2) begin
      wl_clamp = WLW'(2);
    end else if (int'(bus.WL_CYC) > MAX_WL) begin
      wl_clamp = WLW'(MAX_WL);
    end else begin
      wl_clamp = WLW'(bus.WL_CYC);
    end
  end

  // Use the fresh value on the very cycle it becomes loadable so the first
  // write after a latency change is already delayed by the new amount.
  assign wl_eff = ((state_q == S_IDLE) && pipe_empty) ? wl_clamp : wl_q;

  always_ff @(posedge FAB_CLK or negedge ARST_N) begin
    if (!ARST_N) begin
      wl_q  <= WLW'(2);
      run_q <= 1'b0;
    end else begin
      run_q <= 1'b1;
      if ((state_q == S_IDLE) && pipe_empty) begin
        wl_q <= wl_clamp;
      end
    end
  end

  // Stage 1 feeds the output registers; a write injects at stage wl.
  generate
    for (genvar gi = 1; gi <= MAX_WL; gi++) begin : g_stage
      logic inj;
      assign inj = accept && (wl_eff == WLW'(gi));
      if (gi == MAX_WL) begin : g_top
        assign vld_d[gi] = inj;
        assign msk_d[gi] = inj ? bus.WR_MASK : 8'd0;
      end else begin : g_mid
        assign vld_d[gi] = inj | vld_q[gi+1];
        assign msk_d[gi] = inj ? bus.WR_MASK : msk_q[gi+1];
      end
    end
  endgenerate

  always_ff @(posedge FAB_CLK or negedge ARST_N) begin
    if (!ARST_N) begin
      vld_q <= '0;
      msk_q <= '{default: 8'd0};
    end else begin
      vld_q <= vld_d;
      msk_q <= msk_d;
    end
  end

  always_comb begin
    if (vld_q[1]) begin
      oe_d = 4'hF;
    end else begin
      oe_d = {vld_q[2], 2'b00, burst_q};
    end
  end

  always_ff @(posedge FAB_CLK or negedge ARST_N) begin
    if (!ARST_N) begin
      tx_q    <= 8'd0;
      oe_q    <= 4'd0;
      odt_q   <= 1'b0;
      burst_q <= 1'b0;
    end else begin
      tx_q    <= vld_q[1] ? msk_q[1] : 8'd0;
      oe_q    <= oe_d;
      odt_q   <= bus.ODT_REQ & (oe_d == 4'd0);
      burst_q <= vld_q[1];
    end
  end

  always_ff @(posedge FAB_CLK or negedge ARST_N) begin
    if (!ARST_N) begin
      state_q   <= S_IDLE;
      steps_q   <= 8'd0;
      gap_q     <= '0;
      dir_lat_q <= 1'b0;
      is_load_q <= 1'b0;
      dir_q     <= 1'b0;
      move_q    <= 1'b0;
      load_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.DLY_LOAD_REQ) begin
            is_load_q <= 1'b1;
            err_q     <= 1'b0;
            state_q   <= S_DRAIN;
          end else if (bus.DLY_REQ) begin
            is_load_q <= 1'b0;
            err_q     <= 1'b0;
            dir_lat_q <= bus.DLY_DIR;
            steps_q   <= bus.DLY_STEPS;
            state_q   <= S_DRAIN;
          end
        end
        // An empty pipeline with OE already idle means the postamble is out.
        S_DRAIN: begin
          if (pipe_empty && (oe_q == 4'd0)) begin
            if (is_load_q) begin
              load_q  <= 1'b1;
              state_q <= S_LOAD;
            end else begin
              dir_q   <= dir_lat_q;
              state_q <= S_SETUP;
            end
          end
        end
        S_LOAD: begin
          load_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= S_DONE;
        end
        S_SETUP: begin
          if (steps_q == 8'd0) begin
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            move_q  <= 1'b1;
            state_q <= S_MOVE;
          end
        end
        S_MOVE: begin
          move_q  <= 1'b0;
          steps_q <= steps_q - 8'd1;
          if (bus.DELAY_LINE_OUT_OF_RANGE_0) begin
            err_q   <= 1'b1;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            gap_q   <= GW'(STEP_GAP - 2);
            state_q <= S_GAP;
          end
        end
        S_GAP: begin
          if (bus.DELAY_LINE_OUT_OF_RANGE_0) begin
            err_q   <= 1'b1;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else if (gap_q == '0) begin
            if (steps_q != 8'd0) begin
              move_q  <= 1'b1;
              state_q <= S_MOVE;
            end else begin
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end
          end else begin
            gap_q <= gap_q - GW'(1);
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.WR_READY               = wr_ready;
  assign bus.DLY_BUSY               = (state_q != S_IDLE);
  assign bus.DLY_DONE               = done_q;
  assign bus.DLY_ERR                = err_q;
  assign bus.TX_DATA_0              = tx_q;
  assign bus.OE_DATA_0              = oe_q;
  assign bus.ODT_EN_0               = odt_q;
  assign bus.DELAY_LINE_MOVE_0      = move_q;
  assign bus.DELAY_LINE_DIRECTION_0 = dir_q;
  assign bus.DELAY_LINE_LOAD_0      = load_q;
endmodule

// File: doc/pf_lpddr3_dm_lane_tx_seq.md
# pf_lpddr3_dm_lane_tx_seq

Fabric-side sequencer for one LPDDR3 data-mask lane, directly upstream of the lane's DM I/O delay block. It accepts per-burst write masks from the memory controller, delays them by the programmed write latency, and emits the 8:1-geared `TX_DATA_0`, `OE_DATA_0` (with preamble/postamble) and `ODT_EN_0` words that the IOD serializes. It also owns the lane's output delay-line stepper (`MOVE`/`DIRECTION`/`LOAD`), which only runs when no write is in flight.

## Interface
- `MAX_WL`, 12: maximum write latency in `FAB_CLK` cycles; sets the delay pipeline depth.
- `STEP_GAP`, 4: `FAB_CLK` cycles from one `DELAY_LINE_MOVE_0` pulse to the next (minimum 2).
- `FAB_CLK`  in  1  fabric clock; one cycle carries one BL8 burst (8 bit-times).
- `ARST_N`  in  1  one clock; asynchronous, active-low reset.
- `WR_VALID`  in  1  write burst request.
- `WR_READY`  out  1  burst accepted on any cycle where `WR_VALID & WR_READY`.
- `WR_MASK`  in  8  bit i = beat i mask (1 = masked, DM driven high); bit 0 is earliest.
- `WL_CYC`  in  4  write latency in cycles; quasi-static.
- `ODT_REQ`  in  1  controller request for pad termination (read window).
- `DLY_REQ`  in  1  request a delay step sequence.
- `DLY_DIR`  in  1  step direction.
- `DLY_STEPS`  in  8  number of steps.
- `DLY_LOAD_REQ`  in  1  request a delay-line load (reset to the programmed value).
- `DLY_BUSY`  out  1  stepper not idle.
- `DLY_DONE`  out  1  one-cycle pulse at the end of a sequence.
- `DLY_ERR`  out  1  out-of-range seen; sticky until the next accepted request.
- `TX_DATA_0`  out  8  to IOD `TX_DATA`.
- `OE_DATA_0`  out  4  to IOD `OE_DATA`; bit j covers bit-times 2j and 2j+1.
- `ODT_EN_0`  out  1  to IOD `ODT_EN`.
- `DELAY_LINE_MOVE_0`  out  1  IOD delay move pulse.
- `DELAY_LINE_DIRECTION_0`  out  1  IOD delay direction.
- `DELAY_LINE_LOAD_0`  out  1  IOD delay load pulse.
- `DELAY_LINE_OUT_OF_RANGE_0`  in  1  from IOD.

## Operation
- **Reset values.** All outputs are 0, including `WR_READY`. The pipeline is flushed and the FSM goes to IDLE. Reset asserted mid-burst or mid-step aborts immediately; no partial OE or MOVE is emitted after reset.
- **Write latency register.** The effective latency `wl` = clamp(`WL_CYC`, 2, `MAX_WL`). It reloads only when the FSM is IDLE and the pipeline holds no valid entry.
- **Burst pipeline.** This is a `MAX_WL`-deep shift register of {valid, mask}. An accept at cycle k injects at tap `wl`. Back-to-back accepts are allowed every cycle.
- **Burst cycle.** In cycle k+`wl`: `TX_DATA_0` = `WR_MASK` and `OE_DATA_0` = 4'hF. Outside burst cycles, `TX_DATA_0` = 0.
- **Preamble/postamble.** In a non-burst cycle, `OE_DATA_0` = (next cycle is a burst ? 4'b1000 : 0) | (previous cycle was a burst ? 4'b0001 : 0). A single idle gap between bursts therefore gives 4'b1001.
- **ODT.** `ODT_EN_0` = `ODT_REQ` & (`OE_DATA_0` == 0), registered together with the OE word.
- **WR_READY.** Equals (state == IDLE) & !`DLY_REQ` & !`DLY_LOAD_REQ`. If `WR_VALID` and a request arrive in the same cycle, the request wins and no write is accepted.
- **FSM states:**
  - IDLE: a request is sampled here only. `DLY_LOAD_REQ` has priority over `DLY_REQ`; the lower-priority request is ignored and must be re-held. On acceptance, `DLY_ERR` is cleared and dir/steps are latched. Next state is DRAIN.
  - DRAIN: wait until no pipeline entry is valid and `OE_DATA_0` == 0 for one full cycle. Next state is LOAD or SETUP.
  - LOAD: `DELAY_LINE_LOAD_0` = 1 for one cycle, then DONE.
  - SETUP: drive `DELAY_LINE_DIRECTION_0` = latched dir for one cycle. If steps == 0, go to DONE; otherwise go to MOVE.
  - MOVE: `DELAY_LINE_MOVE_0` = 1 for one cycle and decrement steps, then GAP.
  - GAP: lasts `STEP_GAP`-1 cycles, then MOVE if steps > 0, else DONE.
  - Abort: `DELAY_LINE_OUT_OF_RANGE_0` high in any MOVE or GAP cycle sets `DLY_ERR` and goes to DONE; remaining steps are discarded.
  - DONE: `DLY_DONE` = 1 for one cycle, then IDLE.
- **Direction hold.** `DELAY_LINE_DIRECTION_0` holds its last value outside SETUP..DONE.
- `DLY_BUSY` = (state != IDLE).

## Timing
- Accept at edge k produces the burst word on the register outputs during cycle k+`wl`. Preamble is at k+`wl`-1 and postamble at k+`wl`+1.
- Request to first MOVE, with an empty pipeline: IDLE (k), DRAIN (k+1), SETUP (k+2), MOVE (k+3).
- MOVE pulses are exactly `STEP_GAP` cycles apart.
- For N steps, `DLY_DONE` occurs at cycle k+3+(N-1)·`STEP_GAP`+`STEP_GAP`, i.e. after the last GAP.
- All outputs are registered; there is no combinational path from inputs to IOD-side outputs.
- `WR_READY` is the only output combinational on inputs.

## Test plan
- **Write latency.** `WL_CYC`=5; single accept at cycle 10 with mask 8'hA5 -> `OE_DATA_0` = 4'b1000 @14, 4'hF @15, 4'b0001 @16; `TX_DATA_0` = 8'hA5 @15 only.
- **Bursts with gaps.** Accepts at 10, 11, 13 with `WL_CYC`=3 -> OE = 1000, F, F, 1001, F, 0001 on cycles 12–17.
- **Step sequence.** Three bursts in flight, then `DLY_REQ` with dir=1, steps=3, `STEP_GAP`=4 -> `WR_READY` low; first MOVE after drain + 1 SETUP cycle; MOVE pulses 4 cycles apart; `DLY_DONE` once; DIRECTION = 1 throughout.
- **Out-of-range abort.** steps=10, OOR asserted after the 2nd MOVE -> no further MOVE, `DLY_ERR` = 1, `DLY_DONE` pulses; the next `DLY_REQ` clears `DLY_ERR`.
- **Reset and clamp.** `WL_CYC`=0 and `WL_CYC`=15 (`MAX_WL`=12) -> latency 2 and 12. `ARST_N` dropped during a GAP and during a burst pipeline -> all outputs 0 immediately; after release, `WR_READY`=1 and no stale OE appears.
- **Load priority.** `DLY_LOAD_REQ` and `DLY_REQ` high together in IDLE -> a single LOAD pulse, no MOVE, `DLY_DONE` pulses.
